// File: rtl/cordic_arb_pkg.sv
// Shared defaults, FSM state type and gain-compensation constant for the CORDIC arbiter.
package cordic_arb_pkg;

   localparam int XY_BITS_DEF    = 16;
   localparam int THETA_BITS_DEF = 16;
   localparam int ITERATIONS_DEF = 16;

   // 32768 / K with K = 1.6467602581, the 16-stage CORDIC gain
   localparam int CORDIC_1 = 19898;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } arb_state_t;

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester, core and result signals of the CORDIC arbiter; slave = arbiter side, master = environment.
interface cordic_arbiter_if
   import cordic_arb_pkg::*;
#(
   parameter int XY_BITS    = XY_BITS_DEF,
   parameter int THETA_BITS = THETA_BITS_DEF
);
   // req_valid[n]/req_ready[n]: operands of requester n are taken in the cycle both are high;
   // res_valid stays high with res_* stable until the cycle res_ready is also high.
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [XY_BITS:0]    req0_x, req0_y, req1_x, req1_y;
   logic [THETA_BITS:0] req0_theta, req1_theta;

   logic                core_init;
   logic [XY_BITS:0]    core_x_i, core_y_i, core_x_o, core_y_o;
   logic [THETA_BITS:0] core_theta_i, core_theta_o;

   logic                res_valid;
   logic                res_ready;
   logic                res_id;
   logic [XY_BITS:0]    res_x, res_y;
   logic [THETA_BITS:0] res_theta;
   logic                busy;

   modport slave (
      input  req_valid, req0_x, req0_y, req0_theta, req1_x, req1_y, req1_theta,
      input  core_x_o, core_y_o, core_theta_o, res_ready,
      output req_ready, core_init, core_x_i, core_y_i, core_theta_i,
      output res_valid, res_id, res_x, res_y, res_theta, busy
   );

   modport master (
      output req_valid, req0_x, req0_y, req0_theta, req1_x, req1_y, req1_theta,
      output core_x_o, core_y_o, core_theta_o, res_ready,
      input  req_ready, core_init, core_x_i, core_y_i, core_theta_i,
      input  res_valid, res_id, res_x, res_y, res_theta, busy
   );

endinterface

// File: rtl/cordic_arbiter_rr_arb2.sv
// Two-way grant selection: round-robin by default, fixed priority to requester 0
// when CORDIC_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   output logic [1:0] o_gnt
);

`ifdef CORDIC_ARB_FIXED_PRIO_EN
   logic w_unused;
   assign w_unused = ^{clk, rst, i_accept};

   always_comb begin
      o_gnt = 2'b00;
      if (i_req[0])      o_gnt = 2'b01;
      else if (i_req[1]) o_gnt = 2'b10;
   end
`else
   // Id of the last winner; reset to 1 so requester 0 wins the first tie.
   logic r_last_grant;

   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = r_last_grant ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_last_grant <= 1'b1;
      else if (i_accept && (|o_gnt))
         r_last_grant <= o_gnt[1];
   end
`endif

endmodule

// File: rtl/cordic_arbiter.sv
// Two-requester front end for one shared iterative CORDIC core (IDLE/LOAD/ITER/DONE).
// Define CORDIC_ARB_FIXED_PRIO_EN for fixed priority to requester 0 instead of round-robin.
module cordic_arbiter
   import cordic_arb_pkg::*;
#(
   parameter int XY_BITS    = XY_BITS_DEF,
   parameter int THETA_BITS = THETA_BITS_DEF,
   parameter int ITERATIONS = ITERATIONS_DEF
) (
   input  logic            clk,
   input  logic            rst,
   cordic_arbiter_if.slave bus,
   output arb_state_t      o_state
);

   localparam int               CNT_W    = $clog2(ITERATIONS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

   arb_state_t          r_state, w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [1:0]          w_gnt;
   logic                w_accept;
   logic                w_iter_last;
   logic                r_id;
   logic [XY_BITS:0]    r_x, r_y, r_res_x, r_res_y;
   logic [THETA_BITS:0] r_theta, r_res_theta;

   rr_arb2 u_rr_arb2 (
      .clk      (clk),
      .rst      (rst),
      .i_req    (bus.req_valid),
      .i_accept (w_accept),
      .o_gnt    (w_gnt)
   );

   assign w_iter_last = (r_state == ITER) && (r_cnt == CNT_LAST);

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         IDLE: begin
            if (|bus.req_valid) begin
               w_accept = 1'b1;
               w_next   = LOAD;
            end
         end
         LOAD:    w_next = ITER;
         ITER:    if (w_iter_last) w_next = DONE;
         DONE:    if (bus.res_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Operands and owner are captured at grant and double as the held core inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id    <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_theta <= '0;
      end else if (w_accept) begin
         r_id    <= w_gnt[1];
         r_x     <= w_gnt[1] ? bus.req1_x     : bus.req0_x;
         r_y     <= w_gnt[1] ? bus.req1_y     : bus.req0_y;
         r_theta <= w_gnt[1] ? bus.req1_theta : bus.req0_theta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  r_cnt <= '0;
      else if (r_state == ITER) r_cnt <= w_iter_last ? '0 : r_cnt + 1'b1;
      else                      r_cnt <= '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res_x     <= '0;
         r_res_y     <= '0;
         r_res_theta <= '0;
      end else if (w_iter_last) begin
         r_res_x     <= bus.core_x_o;
         r_res_y     <= bus.core_y_o;
         r_res_theta <= bus.core_theta_o;
      end
   end

   // Ready is combinational so the requester sees acceptance in the grant cycle itself.
   assign bus.req_ready    = ((r_state == IDLE) && !rst) ? w_gnt : 2'b00;
   assign bus.core_init    = (r_state == LOAD);
   assign bus.core_x_i     = r_x;
   assign bus.core_y_i     = r_y;
   assign bus.core_theta_i = r_theta;
   assign bus.res_valid    = (r_state == DONE);
   assign bus.res_id       = r_id;
   assign bus.res_x        = r_res_x;
   assign bus.res_y        = r_res_y;
   assign bus.res_theta    = r_res_theta;
   assign bus.busy         = (r_state != IDLE);
   assign o_state          = r_state;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter with a behavioural vectoring CORDIC core and a grant/result reference model.
`timescale 1ns/1ps
module tb_cordic_arbiter;
   import cordic_arb_pkg::*;

   localparam int  NIT    = ITERATIONS_DEF;
   localparam real K_GAIN = 1.6467602581;
   localparam real PI     = 3.14159265358979;
`ifdef CORDIC_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   arb_state_t dbg_state;

   cordic_arbiter_if bus ();

   cordic_arbiter dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .o_state (dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_init   = 0;
   int cyc      = 0;
   int g_cyc    = 0;
   int last_id  = 1;

   logic [16:0] opx [2];
   logic [16:0] opy [2];
   logic [16:0] opt [2];

   assign bus.req0_x     = opx[0];
   assign bus.req0_y     = opy[0];
   assign bus.req0_theta = opt[0];
   assign bus.req1_x     = opx[1];
   assign bus.req1_y     = opy[1];
   assign bus.req1_theta = opt[1];

   always @(posedge clk) begin
      cyc++;
      if (bus.core_init) n_init++;
   end

   // Behavioural vectoring core: first micro-rotation at load, finished before ITER ends.
   int atan_tab [16] = '{25736, 15193, 8027, 4075, 2045, 1024, 512, 256,
                         128, 64, 32, 16, 8, 4, 2, 1};
   int c_x = 0, c_y = 0, c_z = 0, c_it = NIT;

   function automatic int sx(input logic [16:0] v);
      return int'($signed(v));
   endfunction

   task automatic vec_step(input int i, inout int x, inout int y, inout int z);
      int tx;
      tx = x;
      if (y >= 0) begin
         x = x + (y >>> i);
         y = y - (tx >>> i);
         z = z + atan_tab[i];
      end else begin
         x = x - (y >>> i);
         y = y + (tx >>> i);
         z = z - atan_tab[i];
      end
   endtask

   always @(posedge clk) begin : core_model
      int vx, vy, vz;
      vx = c_x;
      vy = c_y;
      vz = c_z;
      if (bus.core_init) begin
         vx = sx(bus.core_x_i);
         vy = sx(bus.core_y_i);
         vz = sx(bus.core_theta_i);
         vec_step(0, vx, vy, vz);
         c_it <= 1;
      end else if (c_it < NIT) begin
         vec_step(c_it, vx, vy, vz);
         c_it <= c_it + 1;
      end
      c_x <= vx;
      c_y <= vy;
      c_z <= vz;
   end

   assign bus.core_x_o     = c_x[16:0];
   assign bus.core_y_o     = c_y[16:0];
   assign bus.core_theta_o = c_z[16:0];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_near(input string tag, input int obs, input real exp, input int tol);
      n_checks++;
      assert ((real'(obs) >= exp - real'(tol)) && (real'(obs) <= exp + real'(tol))) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0.1f +/- %0d", tag, obs, exp, tol);
      end
   endtask

   task automatic rand_ops(input int n);
      int v;
      opx[n] = 17'($urandom_range(16000, 8000));
      v = int'($urandom_range(32000)) - 16000;
      opy[n] = v[16:0];
      v = int'($urandom_range(16000)) - 8000;
      opt[n] = v[16:0];
   endtask

   // One operation: caller is just after a rising edge; returns just after the handshake edge.
   task automatic run_op(input logic [1:0] vmask, input int hold, input int tol_t);
      int gid, lat, init_at, spurious, n0, v;
      real ex, et;
      logic [50:0] core_seen;
      logic [16:0] x0, y0, t0;

      if (vmask == 2'b11) gid = FIXED ? 0 : ((last_id == 1) ? 0 : 1);
      else                gid = vmask[1] ? 1 : 0;
      x0 = opx[gid];
      y0 = opy[gid];
      t0 = opt[gid];
      ex = K_GAIN * $sqrt(real'(sx(x0)) ** 2 + real'(sx(y0)) ** 2);
      et = real'(sx(t0)) + $atan2(real'(sx(y0)), real'(sx(x0))) * 32768.0;

      n0 = n_init;
      bus.req_valid = vmask;
      lat = 0;
      @(negedge clk);
      while (bus.req_ready == 2'b00 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      g_cyc = cyc;
      check("grant", bus.req_ready, 2'b01 << gid);

      @(posedge clk);
      #1;
      bus.req_valid[gid] = 1'b0;
      v = int'($urandom);
      opx[gid] = v[16:0];
      opy[gid] = v[31:15];
      opt[gid] = ~v[16:0];

      lat = 0;
      init_at = -1;
      spurious = 0;
      core_seen = '0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.core_init && init_at < 0) begin
            init_at = lat;
            core_seen = {bus.core_x_i, bus.core_y_i, bus.core_theta_i};
         end
         if (bus.req_ready != 2'b00) spurious++;
      end while (!bus.res_valid && lat < 60);
      check("latency", lat, NIT + 2);
      check("init_cycle", init_at, 1);
      check("core_ops", core_seen, {x0, y0, t0});
      check("res_id", bus.res_id, gid);
      check_near("res_x", sx(bus.res_x), ex, 40);
      check_near("res_y", sx(bus.res_y), 0.0, 16);
      check_near("res_theta", sx(bus.res_theta), et, tol_t);

      for (int d = 0; d < hold; d++) begin
         @(negedge clk);
         check("hold_valid", {bus.res_valid, bus.busy, bus.res_id}, {1'b1, 1'b1, gid[0]});
         check_near("hold_theta", sx(bus.res_theta), et, tol_t);
         if (bus.req_ready != 2'b00) spurious++;
      end
      check("no_grant_busy", spurious, 0);

      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
      check("idle_after", bus.busy, 1'b0);
      check("init_once", n_init - n0, 1);
      last_id = gid;
   endtask

   initial begin : stimulus
      int c1, seen, ang;
      logic [1:0] vm;

      bus.req_valid = 2'b00;
      bus.res_ready = 1'b0;
      for (int n = 0; n < 2; n++) begin
         opx[n] = '0;
         opy[n] = '0;
         opt[n] = '0;
      end

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_outputs", {bus.req_ready, bus.core_init, bus.core_x_i, bus.core_y_i,
                            bus.core_theta_i, bus.res_valid, bus.res_id, bus.res_x,
                            bus.res_y, bus.res_theta, bus.busy}, '0);
      check("rst_state", dbg_state, IDLE);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 30 degree vector on requester 0
      opx[0] = 17'd28377;
      opy[0] = 17'd16383;
      opt[0] = 17'd0;
      run_op(2'b01, 0, 8);
      check_near("theta_30deg", sx(bus.res_theta), 17157.0, 8);

      // Simultaneous requests, back to back with res_ready high
      rand_ops(0);
      rand_ops(1);
      run_op(2'b11, 0, 16);
      c1 = g_cyc;
      rand_ops(0);
      rand_ops(1);
      run_op(2'b11, 0, 16);
      check("throughput", g_cyc - c1, NIT + 3);
      rand_ops(0);
      rand_ops(1);
      run_op(2'b11, 0, 16);

      // Result held back for 5 cycles with the other requester pending
      rand_ops(0);
      rand_ops(1);
      run_op(2'b11, 5, 16);
      bus.req_valid = 2'b00;

      // Reset in ITER cycle 7
      rand_ops(0);
      bus.req_valid = 2'b01;
      c1 = 0;
      @(negedge clk);
      while (bus.req_ready == 2'b00 && c1 < 40) begin
         @(negedge clk);
         c1++;
      end
      check("grant_pre_rst", bus.req_ready, 2'b01);
      @(posedge clk);
      #1;
      bus.req_valid = 2'b00;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_outputs", {bus.req_ready, bus.core_init, bus.core_x_i, bus.core_y_i,
                                bus.core_theta_i, bus.res_valid, bus.res_id, bus.res_x,
                                bus.res_y, bus.res_theta, bus.busy}, '0);
      @(negedge clk);
      rst = 1'b0;
      last_id = 1;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.res_valid) seen = 1;
      end
      check("no_res_after_rst", seen, 0);
      @(posedge clk);
      #1;
      rand_ops(0);
      rand_ops(1);
      run_op(2'b11, 0, 16);

      // 0..90 degree table of gain-compensated unit vectors
      for (int a = 0; a <= 90; a++) begin
         ang = a;
         for (int n = 0; n < 2; n++) begin
            opx[n] = 17'(int'(real'(CORDIC_1) * $cos(real'(ang) * PI / 180.0)));
            opy[n] = 17'(int'(real'(CORDIC_1) * $sin(real'(ang) * PI / 180.0)));
            opt[n] = 17'd0;
         end
         vm = 2'($urandom_range(3, 1));
         run_op(vm, 0, 12);
         check_near("angle_table", sx(bus.res_theta), real'(ang) * PI / 180.0 * 32768.0, 12);
      end

      // Random traffic with random result back-pressure
      for (int k = 0; k < 30; k++) begin
         rand_ops(0);
         rand_ops(1);
         vm = 2'($urandom_range(3, 1));
         run_op(vm, int'($urandom_range(3)), 16);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
